// File: rtl/mem_wb_hilo_pkg.sv
// Shared widths and constants for the MEM/WB pipeline register and HI/LO storage.
// The WB stage record and its bubble value are defined here as well.
package mem_wb_hilo_pkg;

   localparam int RegBus     = 32;
   localparam int RegAddrBus = 5;

   localparam logic [RegAddrBus-1:0] NOPRegAddr   = '0;
   localparam logic [RegBus-1:0]     ZeroWord     = '0;
   localparam logic                  WriteEnable  = 1'b1;
   localparam logic                  WriteDisable = 1'b0;
   localparam logic                  RstEnable    = 1'b0;

   typedef struct packed {
      logic [RegAddrBus-1:0] wd;
      logic                  wreg;
      logic [RegBus-1:0]     wdata;
      logic [RegBus-1:0]     hi;
      logic [RegBus-1:0]     lo;
      logic                  whilo;
      logic                  valid;
   } wb_stage_t;

   function automatic wb_stage_t wb_bubble();
      wb_stage_t b;
      b.wd    = NOPRegAddr;
      b.wreg  = WriteDisable;
      b.wdata = ZeroWord;
      b.hi    = ZeroWord;
      b.lo    = ZeroWord;
      b.whilo = WriteDisable;
      b.valid = 1'b0;
      return b;
   endfunction

endpackage

// File: rtl/mem_wb_hilo_hilo_reg.sv
// Architectural HI/LO registers with a bypass of the pending WB write for EX reads.
module hilo_reg
   import mem_wb_hilo_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [RegBus-1:0] hi_i,
   input  logic [RegBus-1:0] lo_i,
   output logic [RegBus-1:0] hi_o,
   output logic [RegBus-1:0] lo_o,
   output logic [RegBus-1:0] hi_fwd,
   output logic [RegBus-1:0] lo_fwd
);

   logic [RegBus-1:0] hi_q;
   logic [RegBus-1:0] lo_q;

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         hi_q <= ZeroWord;
         lo_q <= ZeroWord;
      end else if (we == WriteEnable) begin
         hi_q <= hi_i;
         lo_q <= lo_i;
      end
   end

   assign hi_o   = hi_q;
   assign lo_o   = lo_q;
   assign hi_fwd = (we == WriteEnable) ? hi_i : hi_q;
   assign lo_fwd = (we == WriteEnable) ? lo_i : lo_q;

endmodule

// File: rtl/mem_wb_hilo.sv
// MEM/WB pipeline register with bubble insertion, HI/LO commit and a retired-instruction counter.
module mem_wb_hilo
   import mem_wb_hilo_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall_mem,
   input  logic                  stall_wb,
   input  logic                  flush,
   input  logic [RegAddrBus-1:0] mem_wd,
   input  logic                  mem_wreg,
   input  logic [RegBus-1:0]     mem_wdata,
   input  logic [RegBus-1:0]     mem_hi,
   input  logic [RegBus-1:0]     mem_lo,
   input  logic                  mem_whilo,
   output logic [RegAddrBus-1:0] wb_wd,
   output logic                  wb_wreg,
   output logic [RegBus-1:0]     wb_wdata,
   output logic [RegBus-1:0]     hi_o,
   output logic [RegBus-1:0]     lo_o,
   output logic [RegBus-1:0]     hi_fwd,
   output logic [RegBus-1:0]     lo_fwd,
   output logic [RegBus-1:0]     retired
);

   wb_stage_t         wb_q;
   logic [RegBus-1:0] retired_q;

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         wb_q      <= wb_bubble();
         retired_q <= ZeroWord;
      end else begin
         // MEM held while WB drains: insert a bubble so the instruction is not issued twice
         if (flush || (stall_mem && !stall_wb)) begin
            wb_q <= wb_bubble();
         end else if (!stall_mem) begin
            wb_q.wd    <= mem_wd;
            wb_q.wreg  <= mem_wreg;
            wb_q.wdata <= mem_wdata;
            wb_q.hi    <= mem_hi;
            wb_q.lo    <= mem_lo;
            wb_q.whilo <= mem_whilo;
            wb_q.valid <= 1'b1;
         end
         if (wb_q.valid && !stall_wb) begin
            retired_q <= retired_q + 32'd1;
         end
      end
   end

   hilo_reg u_hilo_reg (
      .clk    (clk),
      .rst    (rst),
      .we     (wb_q.whilo),
      .hi_i   (wb_q.hi),
      .lo_i   (wb_q.lo),
      .hi_o   (hi_o),
      .lo_o   (lo_o),
      .hi_fwd (hi_fwd),
      .lo_fwd (lo_fwd)
   );

   assign wb_wd    = wb_q.wd;
   assign wb_wreg  = wb_q.wreg;
   assign wb_wdata = wb_q.wdata;
   assign retired  = retired_q;

endmodule

// File: tb/tb_mem_wb_hilo.sv
// Self-checking bench for mem_wb_hilo: directed scenarios followed by random traffic
// checked against a behavioural model of the WB stage, HI/LO and retire count.
module tb_mem_wb_hilo;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_mem, stall_wb, flush;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata, mem_hi, mem_lo;
   logic        mem_whilo;
   logic [4:0]  wb_wd;
   logic        wb_wreg;
   logic [31:0] wb_wdata, hi_o, lo_o, hi_fwd, lo_fwd, retired;

   int n_checks = 0;
   int n_pass   = 0;

   // model of the instruction sitting in WB and architectural state
   logic [4:0]  m_wd;
   logic        m_wreg;
   logic [31:0] m_wdata, m_hi_p, m_lo_p;
   logic        m_whilo, m_valid;
   logic [31:0] m_hi, m_lo, m_ret;

   always #5 clk = ~clk;

   mem_wb_hilo dut (
      .clk       (clk),
      .rst       (rst),
      .stall_mem (stall_mem),
      .stall_wb  (stall_wb),
      .flush     (flush),
      .mem_wd    (mem_wd),
      .mem_wreg  (mem_wreg),
      .mem_wdata (mem_wdata),
      .mem_hi    (mem_hi),
      .mem_lo    (mem_lo),
      .mem_whilo (mem_whilo),
      .wb_wd     (wb_wd),
      .wb_wreg   (wb_wreg),
      .wb_wdata  (wb_wdata),
      .hi_o      (hi_o),
      .lo_o      (lo_o),
      .hi_fwd    (hi_fwd),
      .lo_fwd    (lo_fwd),
      .retired   (retired)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic drive(input logic r, input logic sm, input logic sw, input logic fl,
                        input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                        input logic [31:0] hi, input logic [31:0] lo, input logic whilo);
      rst = r; stall_mem = sm; stall_wb = sw; flush = fl;
      mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
      mem_hi = hi; mem_lo = lo; mem_whilo = whilo;
   endtask

   task automatic load_bubble();
      m_wd = '0; m_wreg = 1'b0; m_wdata = '0; m_hi_p = '0; m_lo_p = '0;
      m_whilo = 1'b0; m_valid = 1'b0;
   endtask

   // one clock edge worth of architectural behaviour
   task automatic model_edge();
      if (!rst) begin
         load_bubble();
         m_hi = '0; m_lo = '0; m_ret = '0;
      end else begin
         if (m_whilo) begin
            m_hi = m_hi_p;
            m_lo = m_lo_p;
         end
         if (m_valid && !stall_wb) m_ret = m_ret + 1;
         if (flush || (stall_mem && !stall_wb)) load_bubble();
         else if (!stall_mem) begin
            m_wd = mem_wd; m_wreg = mem_wreg; m_wdata = mem_wdata;
            m_hi_p = mem_hi; m_lo_p = mem_lo; m_whilo = mem_whilo; m_valid = 1'b1;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".wb_wd"},    {27'd0, wb_wd},   {27'd0, m_wd});
      chk({tag, ".wb_wreg"},  {31'd0, wb_wreg}, {31'd0, m_wreg});
      chk({tag, ".wb_wdata"}, wb_wdata, m_wdata);
      chk({tag, ".hi_o"},     hi_o,     m_hi);
      chk({tag, ".lo_o"},     lo_o,     m_lo);
      chk({tag, ".hi_fwd"},   hi_fwd,   m_whilo ? m_hi_p : m_hi);
      chk({tag, ".lo_fwd"},   lo_fwd,   m_whilo ? m_lo_p : m_lo);
      chk({tag, ".retired"},  retired,  m_ret);
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all(tag);
   endtask

   initial begin
      load_bubble();
      m_hi = 32'hDEAD_0001; m_lo = 32'hDEAD_0002; m_ret = 32'hDEAD_0003;

      // reset held two cycles with writes requested
      drive(0, 0, 0, 0, 5'd7, 1, 32'hFFFF_FFFF, 32'h1, 32'h2, 1);
      cycle("rst0");
      cycle("rst1");
      chk("rst.wb_wd_zero", {27'd0, wb_wd}, 32'd0);
      chk("rst.retired_zero", retired, 32'd0);

      // pass-through
      drive(1, 0, 0, 0, 5'd5, 1, 32'h1234, 32'h0, 32'h0, 0);
      cycle("pass");
      chk("pass.wb_wd5", {27'd0, wb_wd}, 32'd5);
      chk("pass.wdata", wb_wdata, 32'h1234);
      drive(1, 0, 0, 0, 5'd0, 0, 32'h0, 32'h0, 32'h0, 0);
      cycle("pass.ret");
      chk("pass.retired1", retired, 32'd1);

      // HI/LO write: forwarded first, architectural one cycle later
      drive(1, 0, 0, 0, 5'd0, 0, 32'h0, 32'hA, 32'hB, 1);
      cycle("hilo.fwd");
      chk("hilo.hi_fwd", hi_fwd, 32'hA);
      chk("hilo.lo_fwd", lo_fwd, 32'hB);
      drive(1, 0, 0, 0, 5'd0, 0, 32'h0, 32'h0, 32'h0, 0);
      cycle("hilo.arch");
      chk("hilo.hi_o", hi_o, 32'hA);
      chk("hilo.lo_o", lo_o, 32'hB);

      // stall bubble, then full hold
      drive(1, 1, 0, 0, 5'd9, 1, 32'h55, 32'h0, 32'h0, 0);
      cycle("stall.bubble");
      chk("stall.wb_wreg0", {31'd0, wb_wreg}, 32'd0);
      drive(1, 0, 0, 0, 5'd12, 1, 32'h77, 32'h0, 32'h0, 0);
      cycle("stall.load");
      drive(1, 1, 1, 0, 5'd3, 0, 32'h99, 32'h0, 32'h0, 0);
      cycle("stall.hold0");
      cycle("stall.hold1");
      chk("stall.held_wd", {27'd0, wb_wd}, 32'd12);

      // flush beats a double stall; a WB HI/LO write still commits
      drive(1, 0, 0, 0, 5'd4, 1, 32'h44, 32'hC0DE, 32'hBEEF, 1);
      cycle("flush.load");
      drive(1, 1, 1, 1, 5'd6, 1, 32'h66, 32'h0, 32'h0, 0);
      cycle("flush.kill");
      chk("flush.wreg0", {31'd0, wb_wreg}, 32'd0);
      chk("flush.hi_commit", hi_o, 32'hC0DE);

      // retire counter wraps
      drive(1, 0, 0, 0, 5'd1, 1, 32'h1, 32'h0, 32'h0, 0);
      cycle("wrap.load");
      force dut.retired_q = 32'hFFFF_FFFF;
      #1;
      release dut.retired_q;
      m_ret = 32'hFFFF_FFFF;
      cycle("wrap");
      chk("wrap.retired0", retired, 32'd0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 49) != 0),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 9) == 0),
               5'($urandom), 1'($urandom), $urandom, $urandom, $urandom, 1'($urandom));
         cycle("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_wb_hilo.md
MEM_WB_HILO -- requirements
Module: mem_wb_hilo

Interface
REQ-001 The block SHALL have a single clock and a reset that is synchronous and active-low; the ports SHALL be named clk and rst.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-low reset; reset is applied when rst==0 at a clk edge.
REQ-004 stall_mem  in  1  MEM stage held this cycle.
REQ-005 stall_wb  in  1  WB stage held this cycle.
REQ-006 flush  in  1  pipeline flush; kills the MEM-stage instruction.
REQ-007 mem_wd  in  5  destination register address from MEM.
REQ-008 mem_wreg  in  1  register-write enable from MEM.
REQ-009 mem_wdata  in  32  register write data from MEM.
REQ-010 mem_hi, mem_lo  in  32 each  HI/LO write values from MEM.
REQ-011 mem_whilo  in  1  HI/LO write enable from MEM.
REQ-012 wb_wd, wb_wreg, wb_wdata  out  5/1/32  registered write-back to the register file.
REQ-013 hi_o, lo_o  out  32 each  architectural HI/LO contents.
REQ-014 hi_fwd, lo_fwd  out  32 each  HI/LO values with the pending WB write already applied, for EX-stage reads.
REQ-015 retired  out  32  count of non-bubble instructions that left WB.

Function
REQ-016 Pipeline register update SHALL have this priority at each clk edge: reset, then flush, then (stall_mem && !stall_wb), then !stall_mem, else hold.
REQ-017 flush==1 SHALL load a bubble: wd=NOPRegAddr (0), wreg=0, wdata=0, hi=lo=0, whilo=0, valid=0.
REQ-018 stall_mem==1 && stall_wb==0 SHALL load the same bubble, so a stalled MEM instruction is not duplicated.
REQ-019 stall_mem==0 SHALL latch all mem_* inputs, with valid=1; latency from MEM to WB outputs is exactly one cycle.
REQ-020 stall_mem==1 && stall_wb==1 SHALL hold every stage register unchanged.
REQ-021 HI/LO registers SHALL be written with the WB-stage hi/lo on each edge where the WB whilo is 1, regardless of stall or flush. A WB-stage instruction is never killed.
REQ-022 hi_o/lo_o SHALL reflect only the HI/LO registers.
REQ-023 hi_fwd/lo_fwd SHALL be combinational: the WB hi/lo when the WB whilo==1, else hi_o/lo_o.
REQ-024 retired SHALL increment by 1 on each edge where WB valid==1 and stall_wb==0.
REQ-025 retired SHALL wrap from 0xFFFFFFFF to 0 with no flag.
REQ-026 A held WB instruction (stall_wb==1) SHALL NOT increment retired again.
REQ-027 A held WB instruction SHALL rewrite HI/LO with the same value, which is harmless.
REQ-028 A 32-bit whilo input is not accepted; mem_whilo SHALL be exactly 1 bit.

Reset
REQ-029 On rst==0 at a clk edge, wb_wd=0, wb_wreg=0, wb_wdata=0, WB hi/lo/whilo=0, valid=0, hi_o=lo_o=0 and retired=0.
REQ-030 Reset SHALL override flush, stall and any in-flight HI/LO write in the same cycle.
REQ-031 The first non-bubble instruction SHALL appear on the wb_* outputs at the first edge after rst returns high with stall_mem==0.

Structure
REQ-032 Bus widths (RegBus 32, RegAddrBus 5), NOPRegAddr, ZeroWord, WriteEnable/WriteDisable and the active-low reset-level constant SHALL live in the shared defines file.
REQ-033 HI/LO storage and the forwarding mux SHALL be a sub-module named hilo_reg, with inputs clk, rst, we, hi_i, lo_i and outputs hi_o, lo_o, hi_fwd, lo_fwd.
REQ-034 The pipeline register and retire counter SHALL be in the top level.

Verification
REQ-035 Reset: hold rst=0 for 2 cycles with mem_wreg=1 and mem_whilo=1 -> all outputs are 0 and retired=0.
REQ-036 Pass-through: mem_wd=5, mem_wreg=1, mem_wdata=0x1234 with no stall -> the next cycle shows wb_wd=5, wb_wreg=1, wb_wdata=0x1234, and retired becomes 1 one edge later.
REQ-037 HI/LO write: mem_whilo=1, mem_hi=0xA, mem_lo=0xB -> hi_fwd=0xA and lo_fwd=0xB one cycle after entry; hi_o=0xA and lo_o=0xB one cycle later.
REQ-038 Stall bubble: stall_mem=1, stall_wb=0 with mem_wreg=1 -> wb_wreg=0 and retired does not increment; stall_mem=stall_wb=1 -> wb_* are held.
REQ-039 Flush vs stall: flush=1 together with stall_mem=stall_wb=1 -> a bubble is loaded, and an existing WB whilo=1 still commits HI/LO.
REQ-040 Wrap: force retired=0xFFFFFFFF and retire one instruction -> retired=0.
